// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - N-requester cache read / write-back bridge onto the simplified AXI master port.
// Optional CRITICAL_WORD_FIRST_EN: cached reads start at the requested word and wrap.
module cache_axi_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int N_RD       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RD-1:0]              rd_req,
  input  logic [N_RD*ADDR_W-1:0]       rd_addr,
  input  logic [N_RD-1:0]              rd_uncached,
  output logic [N_RD-1:0]              rd_valid,
  output logic [LINE_WORDS*DATA_W-1:0] rd_line,
  input  logic                         wl_req,
  input  logic [ADDR_W-1:0]            wl_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] wl_data,
  output logic                         wl_done,
  input  logic                         ws_req,
  input  logic [ADDR_W-1:0]            ws_addr,
  input  logic [DATA_W-1:0]            ws_data,
  output logic                         ws_done,
  output logic                         axi_ren,
  output logic [ADDR_W-1:0]            axi_raddr,
  output logic [3:0]                   axi_rlen,
  input  logic [DATA_W-1:0]            rdata_i,
  input  logic                         rvalid_i,
  output logic                         axi_wen,
  output logic [ADDR_W-1:0]            axi_waddr,
  output logic [DATA_W-1:0]            axi_wdata,
  output logic                         axi_wlast,
  output logic [3:0]                   axi_wlen,
  input  logic                         wresp_i
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int GW = (N_RD > 1) ? $clog2(N_RD) : 1;

  typedef enum logic {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_SINGLE = 2'd1, WR_LINE = 2'd2} wr_state_t;

  rd_state_t                    r_rd_state, w_rd_next;
  wr_state_t                    r_wr_state, w_wr_next;
  logic [GW-1:0]                r_grant, w_grant;
  logic                         w_any_req;
  logic [ADDR_W-1:0]            r_raddr_lat, w_gaddr;
  logic                         r_unc, w_gunc;
  logic [CW-1:0]                r_rcnt, w_widx;
  logic                         w_rd_last;
  logic [LINE_WORDS*DATA_W-1:0] r_line;
  logic [N_RD-1:0]              r_rd_valid;
  logic [CW-1:0]                r_wcnt;
  logic                         w_wcnt_last;
  logic                         r_ws_done, r_wl_done;
  logic                         w_unused;

  assign w_unused = &{1'b0, wl_addr[CW+1:0]};

  // Lowest set index wins; scanning downward leaves the smallest one last.
  always_comb begin
    w_any_req = 1'b0;
    w_grant   = '0;
    w_gaddr   = '0;
    w_gunc    = 1'b0;
    for (int i = N_RD - 1; i >= 0; i--) begin
      if (rd_req[i]) begin
        w_any_req = 1'b1;
        w_grant   = GW'(i);
        w_gaddr   = rd_addr[i*ADDR_W +: ADDR_W];
        w_gunc    = rd_uncached[i];
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_widx = r_unc ? '0 : (r_raddr_lat[CW+1:2] + r_rcnt);
`else
  assign w_widx = r_unc ? '0 : r_rcnt;
`endif
  assign w_rd_last   = r_unc || (r_rcnt == CW'(LINE_WORDS - 1));
  assign w_wcnt_last = (r_wcnt == CW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
      r_wr_state <= WR_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (w_any_req) w_rd_next = RD_BURST;
      RD_BURST: if (rvalid_i && w_rd_last) w_rd_next = RD_IDLE;
      default:  w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if (ws_req)      w_wr_next = WR_SINGLE;
        else if (wl_req) w_wr_next = WR_LINE;
      end
      WR_SINGLE: if (wresp_i) w_wr_next = WR_IDLE;
      WR_LINE:   if (wresp_i && w_wcnt_last) w_wr_next = WR_IDLE;
      default:   w_wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    axi_ren   = (r_rd_state == RD_BURST);
    axi_rlen  = '0;
    axi_raddr = '0;
    if (r_rd_state == RD_BURST) begin
      axi_rlen  = r_unc ? 4'd0 : 4'(LINE_WORDS - 1);
      axi_raddr = r_unc ? r_raddr_lat : {r_raddr_lat[ADDR_W-1:CW+2], w_widx, 2'b00};
    end
  end

  always_comb begin
    axi_wen   = 1'b0;
    axi_wlen  = '0;
    axi_wlast = 1'b0;
    axi_waddr = '0;
    axi_wdata = '0;
    case (r_wr_state)
      WR_SINGLE: begin
        axi_wen   = 1'b1;
        axi_wlast = 1'b1;
        axi_waddr = ws_addr;
        axi_wdata = ws_data;
      end
      WR_LINE: begin
        axi_wen   = 1'b1;
        axi_wlen  = 4'(LINE_WORDS - 1);
        axi_wlast = w_wcnt_last;
        axi_waddr = {wl_addr[ADDR_W-1:CW+2], r_wcnt, 2'b00};
        axi_wdata = wl_data[r_wcnt*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_raddr_lat <= '0;
      r_unc       <= 1'b0;
      r_rcnt      <= '0;
      r_line      <= '0;
      r_rd_valid  <= '0;
    end else begin
      r_rd_valid <= '0;
      if (r_rd_state == RD_IDLE) begin
        if (w_any_req) begin
          r_grant     <= w_grant;
          r_raddr_lat <= w_gaddr;
          r_unc       <= w_gunc;
          r_rcnt      <= '0;
        end
      end else if (rvalid_i) begin
        r_line[w_widx*DATA_W +: DATA_W] <= rdata_i;
        r_rcnt                          <= r_rcnt + CW'(1);
        if (w_rd_last) r_rd_valid <= N_RD'(1) << r_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_ws_done <= 1'b0;
      r_wl_done <= 1'b0;
    end else begin
      r_ws_done <= (r_wr_state == WR_SINGLE) && wresp_i;
      r_wl_done <= (r_wr_state == WR_LINE) && wresp_i && w_wcnt_last;
      if (r_wr_state != WR_LINE) r_wcnt <= '0;
      else if (wresp_i)          r_wcnt <= r_wcnt + CW'(1);
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_line  = r_line;
  assign ws_done  = r_ws_done;
  assign wl_done  = r_wl_done;
endmodule
